// File: rtl/touch_pkg.sv
// Shared definitions for the touch-panel pin conditioners: width-measurement
// FSM state type and default timing parameters.
package touch_pkg;

  // Width-measurement FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    STUCK = 2'd2
  } busy_state_e;

  // Stable clocks required before a conditioned pin follows the raw pin
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  // Busy-high clocks before the stuck-busy flag asserts
  localparam int DEF_TIMEOUT_CYCLES = 1000;

  // Default width of the pulse-width counter
  localparam int DEF_WIDTH_W = 16;

endpackage

// File: rtl/touch_busy_filter.sv
// Generic pin conditioner: 2-flop synchroniser, debounce counter and
// registered rise/fall pulses. Shared by the BUSY and PENIRQ paths.
module touch_busy_filter
  import touch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_raw,
  output logic pin_clean,
  output logic pin_rise,
  output logic pin_fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             clean_r;
  logic             clean_d_r;
  logic             rise_r;
  logic             fall_r;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pin_raw;
      sync2_r <= sync1_r;
    end
  end

  // Follow the synchronised pin only after it has differed for DEBOUNCE_CYCLES clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= CNT_ZERO;
      clean_r <= 1'b0;
    end else if (sync2_r != clean_r) begin
      if (cnt_r == CNT_LAST) begin
        clean_r <= sync2_r;
        cnt_r   <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

  // One-clock pulses in the cycle after the debounced level changes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clean_d_r <= 1'b0;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
    end else begin
      clean_d_r <= clean_r;
      rise_r    <= clean_r & ~clean_d_r;
      fall_r    <= ~clean_r & clean_d_r;
    end
  end

  assign pin_clean = clean_r;
  assign pin_rise  = rise_r;
  assign pin_fall  = fall_r;

endmodule

// File: rtl/touch_busy_conditioner.sv
// Conditions the touch-ADC BUSY pin for the PIO and SPI sequencer: debounced
// level and edges, width of each busy pulse, and a sticky stuck-busy flag.
// Optional feature macro: TOUCH_BUSY_TIMEOUT_EN enables the STUCK state and
// busy_timeout; without it busy_timeout is 0 and timeout_clr is ignored.
module touch_busy_conditioner
  import touch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WIDTH_W         = DEF_WIDTH_W,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               busy_pin,
  input  logic               timeout_clr,
  output logic               busy_clean,
  output logic               busy_rise,
  output logic               busy_fall,
  output logic [WIDTH_W-1:0] busy_width,
  output logic               width_valid,
  output logic               busy_timeout
);

  localparam logic [WIDTH_W-1:0] WCNT_MAX  = {WIDTH_W{1'b1}};
  localparam logic [WIDTH_W-1:0] WCNT_ONE  = WIDTH_W'(1);
  localparam logic [WIDTH_W-1:0] WCNT_ZERO = {WIDTH_W{1'b0}};
`ifdef TOUCH_BUSY_TIMEOUT_EN
  localparam logic [WIDTH_W-1:0] TIMEOUT_VAL = WIDTH_W'(TIMEOUT_CYCLES);
`endif

  logic               clean_s;
  logic               rise_s;
  logic               fall_s;
  busy_state_e        state_r;
  busy_state_e        state_nxt_s;
  logic [WIDTH_W-1:0] wcnt_r;
  logic [WIDTH_W-1:0] wcnt_nxt_s;
  logic               width_upd_s;
  logic [WIDTH_W-1:0] width_r;
  logic               valid_r;
`ifdef TOUCH_BUSY_TIMEOUT_EN
  logic               stuck_set_s;
  logic               timeout_r;
`endif

  touch_busy_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .pin_raw   (busy_pin),
    .pin_clean (clean_s),
    .pin_rise  (rise_s),
    .pin_fall  (fall_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a fall always ends the pulse, even on the timeout clock
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rise_s) state_nxt_s = HIGH;
        else        state_nxt_s = IDLE;
      end
      HIGH: begin
        if (fall_s)           state_nxt_s = IDLE;
`ifdef TOUCH_BUSY_TIMEOUT_EN
        else if (stuck_set_s) state_nxt_s = STUCK;
`endif
        else                  state_nxt_s = HIGH;
      end
`ifdef TOUCH_BUSY_TIMEOUT_EN
      STUCK: begin
        if (fall_s) state_nxt_s = IDLE;
        else        state_nxt_s = STUCK;
      end
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: counter update, width publish strobe
  always_comb begin
    width_upd_s = 1'b0;
    wcnt_nxt_s  = wcnt_r;
    case (state_r)
      IDLE: begin
        if (rise_s) wcnt_nxt_s = WCNT_ONE;
        else        wcnt_nxt_s = wcnt_r;
      end
      HIGH: begin
        if (fall_s) width_upd_s = 1'b1;
        else        width_upd_s = 1'b0;
        if (wcnt_r != WCNT_MAX) wcnt_nxt_s = wcnt_r + WCNT_ONE;
        else                    wcnt_nxt_s = wcnt_r;
      end
      default: begin
        width_upd_s = 1'b0;
        wcnt_nxt_s  = wcnt_r;
      end
    endcase
  end

`ifdef TOUCH_BUSY_TIMEOUT_EN
  // Timeout hit: measurement reached the limit with the pulse still going
  always_comb begin
    stuck_set_s = 1'b0;
    if ((state_r == HIGH) && !fall_s && (wcnt_r == TIMEOUT_VAL)) stuck_set_s = 1'b1;
    else                                                          stuck_set_s = 1'b0;
  end
`endif

  // Width counter and registered width outputs; busy_width holds between pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_r  <= WCNT_ZERO;
      width_r <= WCNT_ZERO;
      valid_r <= 1'b0;
    end else begin
      wcnt_r  <= wcnt_nxt_s;
      valid_r <= width_upd_s;
      if (width_upd_s) width_r <= wcnt_r;
      else             width_r <= width_r;
    end
  end

`ifdef TOUCH_BUSY_TIMEOUT_EN
  // Sticky stuck-busy flag; a set on the same clock as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_r <= 1'b0;
    end else if (stuck_set_s) begin
      timeout_r <= 1'b1;
    end else if (timeout_clr) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign busy_timeout = timeout_r;
`else
  logic [WIDTH_W:0] unused_cfg_s;
  assign unused_cfg_s = {timeout_clr, WIDTH_W'(TIMEOUT_CYCLES)};
  assign busy_timeout = 1'b0;
`endif

  assign busy_clean  = clean_s;
  assign busy_rise   = rise_s;
  assign busy_fall   = fall_s;
  assign busy_width  = width_r;
  assign width_valid = valid_r;

endmodule

// File: tb/tb_touch_busy_conditioner.sv
// Self-checking bench for touch_busy_conditioner. A cycle-level reference
// model derived from the behavioural rules (pin seen two clocks late, level
// follows after DEB stable samples, width = clean-high clocks) is compared
// against every output after every clock. Honours TOUCH_BUSY_TIMEOUT_EN.
module tb_touch_busy_conditioner;

  localparam int DEB = 4;
  localparam int W   = 16;
  localparam int TMO = 1000;
  localparam int SAT = 65535;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         busy_pin = 1'b0;
  logic         timeout_clr = 1'b0;
  logic         busy_clean;
  logic         busy_rise;
  logic         busy_fall;
  logic [W-1:0] busy_width;
  logic         width_valid;
  logic         busy_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int valid_cnt = 0;
  int last_w   = 0;

  // reference model state
  bit pq[$];          // pin values at the last two edges (synchroniser delay)
  bit wq[$];          // last DEB synchronised samples
  bit m_clean, c1, c2, c3;
  int r1, r2, last_len, m_width;
  bit pulse_stuck, m_timeout, exp_rise, exp_fall, exp_valid;

  touch_busy_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .WIDTH_W         (W),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .busy_pin     (busy_pin),
    .timeout_clr  (timeout_clr),
    .busy_clean   (busy_clean),
    .busy_rise    (busy_rise),
    .busy_fall    (busy_fall),
    .busy_width   (busy_width),
    .width_valid  (width_valid),
    .busy_timeout (busy_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    pq = {1'b0, 1'b0};
    wq = {};
    m_clean = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
    r1 = 0; r2 = 0; last_len = 0; m_width = 0;
    pulse_stuck = 1'b0; m_timeout = 1'b0;
    exp_rise = 1'b0; exp_fall = 1'b0; exp_valid = 1'b0;
  endtask

  task automatic model_edge(input bit p, input bit clr);
    bit s, stable, set;
    s = pq.pop_front();
    pq.push_back(p);
    wq.push_back(s);
    if (wq.size() > DEB) void'(wq.pop_front());
    stable = (wq.size() == DEB);
    foreach (wq[i]) if (wq[i] == m_clean) stable = 1'b0;
    c3 = c2; c2 = c1; c1 = m_clean;
    if (stable) m_clean = ~m_clean;
    exp_rise = c1 & ~c2;
    exp_fall = ~c1 & c2;
    set = 1'b0;
`ifdef TOUCH_BUSY_TIMEOUT_EN
    // measurement lags the clean level by two clocks; a pulse longer than TMO is stuck
    set = (r2 == TMO + 1);
`endif
    if (set) pulse_stuck = 1'b1;
    m_timeout = set | (m_timeout & ~clr);
    exp_valid = 1'b0;
    if (!c2 && c3) begin
      if (!pulse_stuck) begin
        exp_valid = 1'b1;
        m_width = (last_len > SAT) ? SAT : last_len;
      end
      pulse_stuck = 1'b0;
    end
    if (c1 && !m_clean) last_len = r1;
    r2 = r1;
    r1 = m_clean ? r1 + 1 : 0;
  endtask

  task automatic check_all();
    check("clean",   busy_clean,   m_clean);
    check("rise",    busy_rise,    exp_rise);
    check("fall",    busy_fall,    exp_fall);
    check("valid",   width_valid,  exp_valid);
    check("width",   busy_width,   m_width);
    check("timeout", busy_timeout, m_timeout);
  endtask

  task automatic step(input bit p, input bit clr);
    busy_pin = p;
    timeout_clr = clr;
    @(posedge clk);
    cyc++;
    model_edge(p, clr);
    #1;
    check_all();
    if (width_valid) begin
      valid_cnt++;
      last_w = busy_width;
    end
  endtask

  task automatic hold(input bit p, input int n);
    for (int i = 0; i < n; i++) step(p, 1'b0);
  endtask

  initial begin
    int lat;
    int v0;
    // reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;

    // 1: level latency and rise pulse
    hold(1'b0, 5);
    lat = 0;
    do begin
      step(1'b1, 1'b0);
      lat++;
    end while (!busy_clean && lat < 20);
    check("rise_latency", lat, 6);
    hold(1'b1, 10);
    hold(1'b0, 10);

    // 2: glitch shorter than debounce is ignored
    v0 = valid_cnt;
    hold(1'b1, 3);
    hold(1'b0, 12);
    check("glitch_no_valid", valid_cnt - v0, 0);

    // 3: clean 50-clock pulse
    v0 = valid_cnt;
    hold(1'b1, 50);
    hold(1'b0, 10);
    check("w50_count", valid_cnt - v0, 1);
    check("w50_width", last_w, 50);

`ifdef TOUCH_BUSY_TIMEOUT_EN
    // 4: boundary pulses, stuck busy, sticky flag, set-wins
    v0 = valid_cnt;
    hold(1'b1, TMO);
    hold(1'b0, 10);
    check("w_at_limit_cnt", valid_cnt - v0, 1);
    check("w_at_limit", last_w, TMO);
    check("tmo_not_set", busy_timeout, 0);
    v0 = valid_cnt;
    hold(1'b1, 1200);
    hold(1'b0, 10);
    check("stuck_no_valid", valid_cnt - v0, 0);
    check("tmo_sticky", busy_timeout, 1);
    check("width_held", last_w, TMO);
    step(1'b0, 1'b1);
    check("tmo_cleared", busy_timeout, 0);
    hold(1'b0, 10);
    hold(1'b1, 1007);
    check("tmo_pre", busy_timeout, 0);
    step(1'b1, 1'b1);
    check("tmo_set_wins", busy_timeout, 1);
    hold(1'b1, 20);
    hold(1'b0, 10);
    step(1'b0, 1'b1);
    hold(1'b0, 5);
`endif

    // 5: reset mid-pulse with pin held high
    hold(1'b1, 27);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    v0 = valid_cnt;
    lat = 0;
    do begin
      step(1'b1, 1'b0);
      lat++;
    end while (!busy_clean && lat < 20);
    check("rst_rise_latency", lat, 6);
    hold(1'b1, 33);
    hold(1'b0, 10);
    check("rst_w_count", valid_cnt - v0, 1);
    check("rst_width", last_w, 39);

`ifndef TOUCH_BUSY_TIMEOUT_EN
    // 6: width saturates, no timeout without the feature
    hold(1'b1, 66000);
    hold(1'b0, 10);
    check("sat_width", last_w, SAT);
    step(1'b0, 1'b1);
`endif

    // randomized pulse train with occasional clear pulses
    for (int k = 0; k < 80; k++) begin
      bit lvl;
      int len;
      lvl = k[0];
      len = int'($urandom_range(1, 40));
      for (int j = 0; j < len; j++) step(lvl, ($urandom_range(0, 7) == 0));
    end
    hold(1'b0, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
